// File: rtl/imm_field_decoder.sv
// Decode-stage immediate-field decoder: registers extend[10:0], imm_sel, PC+2 and flags behind a ready/valid stage.
// Define IMM_DEC_SKID_BUF_EN for a two-entry skid buffer with a registered in_ready; default is a single entry.
module imm_field_decoder #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instr,
  input  logic [PC_W-1:0] pc2_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [10:0]     extend,
  output logic [2:0]      imm_sel,
  output logic [PC_W-1:0] pc2_out,
  output logic            has_imm,
  output logic            illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Payload layout: {has_imm, illegal, imm_sel, pc2, extend}.
  localparam int PW = 2 + 3 + PC_W + 11;

  logic [4:0]    opcode;
  logic [2:0]    dec_sel;
  logic          dec_has;
  logic          dec_ill;
  logic [PW-1:0] new_pay;
  logic [PW-1:0] head_pay;

  assign opcode = instr[15:11];

  always_comb begin
    dec_sel = 3'b000;
    dec_has = 1'b1;
    dec_ill = 1'b0;
    case (opcode)
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: dec_sel = 3'b000;
      5'b01010, 5'b01011, 5'b10100, 5'b10101,
      5'b10110, 5'b10111:                               dec_sel = 3'b001;
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b10010, 5'b00101:                     dec_sel = 3'b010;
      5'b00100:                                         dec_sel = 3'b011;
      5'b00110, 5'b00111:                               dec_sel = 3'b100;
      5'b00000, 5'b00001, 5'b00010, 5'b00011,
      5'b11001, 5'b11010, 5'b11011, 5'b11100,
      5'b11101, 5'b11110, 5'b11111:                     dec_has = 1'b0;
      default: begin
        dec_has = 1'b0;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign new_pay = {dec_has, dec_ill, dec_sel, pc2_in, instr[10:0]};

`ifdef IMM_DEC_SKID_BUF_EN
  // Two-entry FIFO; e0 is always the head presented downstream.
  logic [1:0]    count_q, count_d;
  logic [PW-1:0] e0_q, e0_d;
  logic [PW-1:0] e1_q, e1_d;
  logic          in_ready_q, in_ready_d;
  logic          push;
  logic          pop;

  assign push = in_valid & in_ready_q & ~flush;
  assign pop  = (count_q != 2'd0) & out_ready;

  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) e0_d = new_pay;
        else                 e1_d = new_pay;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = new_pay;
        end else begin
          e0_d = e1_q;
          e1_d = new_pay;
        end
      end
      default: ;
    endcase
    if (flush) count_d = 2'd0;
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      e0_q       <= '0;
      e1_q       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign head_pay  = e0_q;
`else
  logic          valid_q, valid_d;
  logic [PW-1:0] pay_q, pay_d;
  logic          accept;

  // A full entry can be replaced in the same cycle it drains, so there is no bubble.
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (accept) begin
      valid_d = 1'b1;
      pay_d   = new_pay;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign out_valid = valid_q;
  assign head_pay  = pay_q;
`endif

  assign {has_imm, illegal, imm_sel, pc2_out, extend} = head_pay;

endmodule

// File: tb/tb_imm_field_decoder.sv
// Directed testbench for imm_field_decoder: reset, opcode sweep, stall, flush, async reset and streaming.
module tb_imm_field_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] pc2_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] extend;
  logic [2:0]  imm_sel;
  logic [15:0] pc2_out;
  logic        has_imm;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  imm_field_decoder #(.PC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc2_in(pc2_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .extend(extend), .imm_sel(imm_sel), .pc2_out(pc2_out),
    .has_imm(has_imm), .illegal(illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

`ifdef IMM_DEC_SKID_BUF_EN
  localparam int EXP_STALL_ACC = 2;
`else
  localparam int EXP_STALL_ACC = 1;
`endif

  // Hand-derived imm_sel per opcode 0..31.
  logic [2:0] sel_tab [32] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd4, 3'd4,
                               3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                               3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                               3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  // scoreboard: {pc2, extend}
  logic [26:0] exp_q[$];
  logic [15:0] s_instr [16];
  logic [15:0] s_pc2   [16];
  int n_items;
  int idx;
  int acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inputs();
    in_valid = (idx < n_items);
    if (idx < n_items) begin
      instr  = s_instr[idx];
      pc2_in = s_pc2[idx];
    end
  endtask

  task automatic build_stream(input int n, input int seed);
    n_items = n;
    idx = 0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      s_instr[i] = {5'(8 + ((i + seed) % 17)), 11'($urandom_range(0, 2047))};
      s_pc2[i]   = 16'(16'h0200 + 2 * (i + seed * 16));
    end
    load_inputs();
  endtask

  // driver + monitor for one clock: score output/input handshakes, then advance.
  task automatic run_cycle();
    logic [26:0] e;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL order_underflow observed=%0h expected=none", {pc2_out, extend});
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("order", {5'd0, pc2_out, extend}, {5'd0, e});
      end else begin
        chk("stall_hold", {5'd0, pc2_out, extend}, {5'd0, exp_q[0]});
      end
    end
    if (in_valid && in_ready && !flush) begin
      exp_q.push_back({pc2_in, instr[10:0]});
      idx++;
      acc++;
    end
    @(posedge clk);
    #1;
    load_inputs();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc2_in = '0; flush = 1'b0; out_ready = 1'b0;
    n_items = 0; idx = 0; acc = 0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_payload", {1'b0, has_imm, illegal, imm_sel, pc2_out, extend}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // first ADDI
    in_valid = 1'b1; instr = 16'h4123; pc2_in = 16'h0010; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_sel", {29'd0, imm_sel}, 32'd0);
    chk("addi_ext", {21'd0, extend}, 32'h123);
    chk("addi_pc2", {16'd0, pc2_out}, 32'h0010);
    chk("addi_has", {31'd0, has_imm}, 32'd1);
    chk("addi_ill", {31'd0, illegal}, 32'd0);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // opcode sweep, one per cycle with out_ready=1
    for (int op = 0; op < 32; op++) begin
      in_valid = 1'b1;
      instr    = {5'(op), 11'((op * 37 + 5) & 11'h7ff)};
      pc2_in   = 16'(16'h0100 + op * 2);
      tick();
      chk("sweep_valid", {31'd0, out_valid}, 32'd1);
      chk("sweep_sel", {29'd0, imm_sel}, {29'd0, sel_tab[op]});
      chk("sweep_has", {31'd0, has_imm}, (op >= 4 && op <= 24) ? 32'd1 : 32'd0);
      chk("sweep_ill", {31'd0, illegal}, 32'd0);
      chk("sweep_ext", {21'd0, extend}, {21'd0, 11'((op * 37 + 5) & 11'h7ff)});
      chk("sweep_pc2", {16'd0, pc2_out}, 32'(16'h0100 + op * 2));
    end
    in_valid = 1'b0;
    tick();

    // explicit JAL / J / XORI selects
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 16'h3000; tick();
    chk("jal_sel", {29'd0, imm_sel}, 32'd4);
    instr = 16'h2000; tick();
    chk("j_sel", {29'd0, imm_sel}, 32'd3);
    instr = 16'h5055; tick();
    chk("xori_sel", {29'd0, imm_sel}, 32'd1);
    in_valid = 1'b0;
    tick();

    // stall: 4 offered, out_ready=0 for 3 cycles
    exp_q.delete();
    out_ready = 1'b0;
    build_stream(4, 1);
    for (int c = 0; c < 3; c++) run_cycle();
    chk("stall_accepts", 32'(acc), 32'(EXP_STALL_ACC));
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx == n_items && exp_q.size() == 0) break;
      run_cycle();
    end
    chk("stall_all_in", 32'(idx), 32'd4);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // flush with entries held and a new input offered
    out_ready = 1'b0;
    build_stream(2, 2);
    run_cycle();
    run_cycle();
    in_valid = 1'b1; instr = 16'h47AB; pc2_in = 16'hBEEF; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // asynchronous reset pulse mid-stream
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 16'h8155; pc2_in = 16'h1234;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_payload", {1'b0, has_imm, illegal, imm_sel, pc2_out, extend}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; instr = 16'h6A0F; pc2_in = 16'h0042;
    tick();
    in_valid = 1'b0;
    chk("post_rst_lat", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", {5'd0, pc2_out, extend}, {5'd0, 16'h0042, 11'h20F});
    chk("post_rst_sel", {29'd0, imm_sel}, 32'd2);
    tick();

    // back-to-back 8 with out_ready=1
    exp_q.delete();
    out_ready = 1'b1;
    build_stream(8, 3);
    for (int k = 0; k < 9; k++) begin
      run_cycle();
      chk("b2b_valid", {31'd0, out_valid}, (k < 8) ? 32'd1 : 32'd0);
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
    chk("b2b_accepts", 32'(acc), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_field_decoder.md
# imm_field_decoder

Decode-stage block that turns a fetched 16-bit instruction into the immediate-field payload (`extend[10:0]`) and the 3-bit immediate select code consumed by the immediate extender. It also forwards PC+2 alongside. It sits between the IF/ID register and the immediate extender as a registered ready/valid pipeline stage. The stage honours downstream back-pressure and a pipeline flush.

## Interface
- `PC_W`, 16, width of the PC+2 value carried with each instruction.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  16  instruction word; opcode = `instr[15:11]`.
- `pc2_in`  in  PC_W  PC+2 of `instr`.
- `flush`  in  1  discard all held and incoming instructions.
- `out_valid`  out  1  decoded payload available.
- `out_ready`  in  1  downstream accepts this cycle.
- `extend`  out  11  `instr[10:0]` of the held instruction.
- `imm_sel`  out  3  select code (000 5S, 001 5Z, 010 8S, 011 11S, 100 PC+2).
- `pc2_out`  out  PC_W  PC+2 of the held instruction.
- `has_imm`  out  1  instruction uses an immediate/PC+2 operand.
- `illegal`  out  1  opcode not in the ISA.

## Operation
- Transfer in on `in_valid & in_ready`; transfer out on `out_valid & out_ready`.
- `imm_sel` is decoded from the opcode and registered with the entry:
  - ADDI 01000, SUBI 01001, ST 10000, LD 10001, STU 10011 → 000.
  - XORI 01010, ANDNI 01011, ROLI/SLLI/RORI/SRLI 10100–10111 → 001.
  - BEQZ/BNEZ/BLTZ/BGEZ 01100–01111, LBI 11000, SLBI 10010 → 010. For SLBI the ALU consumes only the low 8 bits.
  - J 00100 → 011.
  - JAL 00110, JALR 00111 → 100, the link value.
  - JR 00101 → 010.
- For the entries above, `has_imm`=1.
- HALT 00000, NOP 00001, SIIC 00010, RTI 00011, and R-type 11001–11111 → `imm_sel`=000, `has_imm`=0, `illegal`=0.
- Any other opcode → `imm_sel`=000, `has_imm`=0, `illegal`=1.
- Codes 101–111 are never emitted.
- `extend` and `pc2_out` are copied unmodified from the accepted entry.
- `flush` (synchronous) empties every entry. Any input offered in the same cycle is dropped, even if `in_ready`=1. An output handshake in that same cycle still counts as completed.
- Outputs hold stable while `out_valid & ~out_ready`.
- `rst_n` low, including mid-transfer: all entries empty immediately.
  - `out_valid`=0; `extend`, `imm_sel`, `pc2_out`, `has_imm`, `illegal` = 0.
  - `in_ready` = 1 once `rst_n` is high.

## Timing
- Latency: accepted in cycle N → `out_valid` in cycle N+1.
- Throughput: one instruction per cycle when `out_ready` is held 1.
- Full: no accept while every entry is occupied and `out_ready`=0.
- Simultaneous in/out handshake on a full single entry (non-skid build): new entry replaces old, with no bubble.
- Empty with `out_ready`=1: no output; `out_ready` is ignored while `out_valid`=0.
- `flush` at N → `out_valid`=0 at N+1.

## Configuration
- `IMM_DEC_SKID_BUF_EN` defined:
  - Two-entry skid buffer.
  - `in_ready` is a register output: `in_ready` = (fewer than 2 entries occupied), with no combinational path from `out_ready`.
  - Entries drain in FIFO order.
- Undefined:
  - Single entry.
  - `in_ready` = `~out_valid | out_ready`, combinational.

## Test plan
- Reset release, `in_valid`=1, `instr`=16'h4123 (ADDI), `pc2_in`=16'h0010, `out_ready`=1 → next cycle `out_valid`=1, `imm_sel`=000, `extend`=11'h123, `pc2_out`=16'h0010, `has_imm`=1.
- Opcode sweep 00000–11111 → `imm_sel`/`has_imm`/`illegal` match the Operation mapping. JAL 16'h3000 → 100; J 16'h2000 → 011; XORI → 001.
- `out_ready`=0 for 3 cycles with a stream of 4 instructions:
  - Skid build: exactly 2 accepted and `in_ready`=0.
  - Non-skid build: 1 accepted.
  - On release, outputs appear in order and are unchanged while stalled.
- `flush` asserted with 2 entries held and `in_valid`=1 → next cycle `out_valid`=0 and the offered instruction never appears.
- `rst_n` pulsed low mid-stream for half a cycle → all outputs 0 immediately; after release the first new instruction is emitted with 1-cycle latency.
- Back-to-back 8 instructions with `out_ready`=1 → 8 consecutive `out_valid` cycles, starting 1 cycle after the first accept.
